// File: rtl/cpu_trace_checker.sv
// Run-time checker placed beside cpu_top. It keeps a shadow copy of every
// register-file write and streams each write into a trace FIFO. It detects
// halt (the PC parks on one value) or a cycle timeout, then compares the
// shadow registers and the final PC against expectations loaded in IDLE.
module cpu_trace_checker #(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 32,
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 8,
  parameter int TRACE_DEPTH = 16,
  parameter int HALT_CYCLES = 3,
  parameter int TIMEOUT     = 1024,
  localparam int REG_AW     = $clog2(NUM_REGS),
  localparam int TR_W       = PC_W + REG_AW + DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [PC_W-1:0]     pc_in,
  input  logic [INSTR_W-1:0]  instr_in,
  input  logic                rf_we,
  input  logic [REG_AW-1:0]   rf_waddr,
  input  logic [DATA_W-1:0]   rf_wdata,
  input  logic                exp_we,
  input  logic [REG_AW-1:0]   exp_addr,
  input  logic [DATA_W-1:0]   exp_data,
  input  logic [PC_W-1:0]     exp_pc,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic [TR_W-1:0]     trace_data,
  output logic                trace_overflow,
  output logic [31:0]         cycle_count,
  output logic                done,
  output logic                pass,
  output logic [NUM_REGS:0]   fail_mask,
  output logic                timeout
);

  localparam int FA_W = $clog2(TRACE_DEPTH);
  localparam int ST_W = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t                           state;
  logic [NUM_REGS-1:0][DATA_W-1:0]  shadow;
  logic [NUM_REGS-1:0][DATA_W-1:0]  exp_val;
  logic [NUM_REGS-1:0]              chk_mask;
  logic [PC_W-1:0]                  prev_pc;
  logic [PC_W-1:0]                  last_pc;
  logic [PC_W-1:0]                  exp_pc_q;
  logic [ST_W-1:0]                  stable_cnt;
  logic [ST_W-1:0]                  stable_nxt;
  logic [REG_AW-1:0]                chk_idx;
  logic [NUM_REGS:0]                fail_nxt;
  logic                             halt_hit;
  logic                             start_ok;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [TR_W-1:0]                  fifo_mem [TRACE_DEPTH];
  logic [FA_W:0]                    wptr, rptr;
  logic                             fifo_full, fifo_empty, push, pop, push_ok;

  // instr_in is a sideband only; it never takes part in the checks
  logic                             unused_instr;
  assign unused_instr = ^instr_in;

  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[FA_W] != rptr[FA_W]) && (wptr[FA_W-1:0] == rptr[FA_W-1:0]);
  assign push       = (state == S_RUN) && rf_we;
  assign pop        = trace_ready && !fifo_empty;
  // a pop frees the head slot in the same cycle, so a full FIFO still accepts
  assign push_ok    = push && (!fifo_full || pop);
  assign trace_valid = !fifo_empty;
  assign trace_data  = fifo_mem[rptr[FA_W-1:0]];

  // Halt detection: count consecutive write-free cycles at an unchanged PC
  always_comb begin
    stable_nxt = '0;
    if (pc_in == prev_pc && !rf_we) stable_nxt = stable_cnt + 1'b1;
    halt_hit = (stable_nxt == ST_W'(HALT_CYCLES));
  end

  // Next fail mask: one register per CHECK cycle, PC bit on the first
  always_comb begin
    fail_nxt = fail_mask;
    if (state == S_CHECK) begin
      fail_nxt[chk_idx] = chk_mask[chk_idx] & (shadow[chk_idx] != exp_val[chk_idx]);
      if (chk_idx == '0) fail_nxt[NUM_REGS] = !timeout && (last_pc != exp_pc_q);
    end
  end

  // Trace FIFO storage write (no reset needed, guarded by pointers)
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr[FA_W-1:0]] <= {pc_in, rf_waddr, rf_wdata};
  end

  // Trace FIFO pointers and sticky overflow; start flushes the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr           <= '0;
      rptr           <= '0;
      trace_overflow <= 1'b0;
    end else if (start_ok) begin
      wptr           <= '0;
      rptr           <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push && !push_ok) trace_overflow <= 1'b1;
    end
  end

  // Main FSM: expectation load, run monitoring, sequential check, result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      shadow      <= '0;
      exp_val     <= '0;
      chk_mask    <= '0;
      prev_pc     <= '0;
      last_pc     <= '0;
      exp_pc_q    <= '0;
      stable_cnt  <= '0;
      chk_idx     <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_mask   <= '0;
      timeout     <= 1'b0;
    end else begin
      prev_pc <= pc_in;
      if (state == S_IDLE && exp_we) begin
        exp_val[exp_addr]  <= exp_data;
        chk_mask[exp_addr] <= 1'b1;
      end
      if (start_ok) begin
        state       <= S_RUN;
        exp_pc_q    <= exp_pc;
        stable_cnt  <= '0;
        chk_idx     <= '0;
        cycle_count <= '0;
        done        <= 1'b0;
        pass        <= 1'b0;
        fail_mask   <= '0;
        timeout     <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            if (rf_we) shadow[rf_waddr] <= rf_wdata;
            last_pc    <= pc_in;
            stable_cnt <= stable_nxt;
            if (halt_hit) begin
              state   <= S_CHECK;
              chk_idx <= '0;
            end else if (cycle_count == 32'(TIMEOUT - 1)) begin
              state   <= S_CHECK;
              chk_idx <= '0;
              timeout <= 1'b1;
            end
          end
          S_CHECK: begin
            fail_mask <= fail_nxt;
            chk_idx   <= chk_idx + 1'b1;
            if (chk_idx == REG_AW'(NUM_REGS - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (fail_nxt == '0) && !timeout;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed bench for cpu_trace_checker: expectation load, halt/timeout,
// trace FIFO ordering and overflow, and reset mid-run.
module tb_cpu_trace_checker;

  localparam int PC_W = 8, INSTR_W = 32, DATA_W = 16, NUM_REGS = 8;
  localparam int REG_AW = 3, TR_W = PC_W + REG_AW + DATA_W;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [PC_W-1:0]     pc_in = '0;
  logic [INSTR_W-1:0]  instr_in = '0;
  logic                rf_we = 1'b0;
  logic [REG_AW-1:0]   rf_waddr = '0;
  logic [DATA_W-1:0]   rf_wdata = '0;
  logic                exp_we = 1'b0;
  logic [REG_AW-1:0]   exp_addr = '0;
  logic [DATA_W-1:0]   exp_data = '0;
  logic [PC_W-1:0]     exp_pc = '0;
  logic                trace_valid, trace_ready, trace_overflow;
  logic [TR_W-1:0]     trace_data;
  logic [31:0]         cycle_count;
  logic                done, pass, timeout;
  logic [NUM_REGS:0]   fail_mask;

  int total = 0;
  int bad   = 0;

  logic [REG_AW-1:0] wa [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd7};
  logic [DATA_W-1:0] wd [6] = '{16'h1770, 16'h03E8, 16'hABCD, 16'hFFEE, 16'hBEEF, 16'h0007};

  cpu_trace_checker #(.TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pc_in(pc_in), .instr_in(instr_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_pc(exp_pc),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_overflow(trace_overflow), .cycle_count(cycle_count), .done(done),
    .pass(pass), .fail_mask(fail_mask), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PC_W-1:0] epc);
    exp_pc = epc;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wr(input logic [PC_W-1:0] pc, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
    pc_in = pc; rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  // hold the PC and wait (bounded) for done
  task automatic hold_wait(input string tag, input logic [PC_W-1:0] pc);
    int n = 0;
    pc_in = pc; rf_we = 1'b0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic pop_chk(input string tag, input logic [TR_W-1:0] exp);
    chk({tag, "_vld"}, trace_valid, 1'b1);
    chk(tag, trace_data, exp);
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
  endtask

  initial begin
    trace_ready = 1'b0;
    #12 reset_n = 1'b1;
    tick();
    // 1: reset state
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_tvalid", trace_valid, 0);
    chk("rst_ovf", trace_overflow, 0);
    chk("rst_cyc", cycle_count, 0);
    chk("rst_mask", fail_mask, 0);
    chk("rst_to", timeout, 0);

    // 2: load expectations, replay matching writes, halt at 08
    for (int i = 0; i < 6; i++) begin
      exp_we = 1'b1; exp_addr = wa[i]; exp_data = wd[i];
      tick();
    end
    exp_we = 1'b0;
    do_start(8'h08);
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i), wa[i], wd[i]);
    hold_wait("t2_done", 8'h08);
    chk("t2_pass", pass, 1);
    chk("t2_mask", fail_mask, 0);
    chk("t2_to", timeout, 0);
    chk("t2_cyc", cycle_count, 10);
    for (int i = 0; i < 6; i++) pop_chk("t2_trace", {8'h10 + 8'(i), wa[i], wd[i]});
    chk("t2_empty", trace_valid, 0);

    // 3a: R4 written wrong
    do_start(8'h08);
    for (int i = 0; i < 6; i++) wr(8'h20, wa[i], (i == 3) ? 16'hFFEF : wd[i]);
    hold_wait("t3a_done", 8'h08);
    chk("t3a_pass", pass, 0);
    chk("t3a_mask", fail_mask, 9'h010);
    // 3b: also halt at the wrong PC; start clears the FIFO
    do_start(8'h08);
    chk("t3b_flush", trace_valid, 0);
    for (int i = 0; i < 6; i++) wr(8'h20, wa[i], (i == 3) ? 16'hFFEF : wd[i]);
    hold_wait("t3b_done", 8'h09);
    chk("t3b_mask", fail_mask, 9'h110);
    chk("t3b_pass", pass, 0);

    // 4a: 18 writes with no consumer -> overflow, first 16 kept
    do_start(8'h08);
    for (int i = 0; i < 18; i++) wr(8'(i), 3'(i), 16'h0100 + 16'(i));
    chk("t4_ovf", trace_overflow, 1);
    hold_wait("t4_done", 8'h40);
    for (int i = 0; i < 16; i++) pop_chk("t4_trace", {8'(i), 3'(i), 16'h0100 + 16'(i)});
    chk("t4_empty", trace_valid, 0);
    chk("t4_ovf_sticky", trace_overflow, 1);
    // 4b: full FIFO, push and pop in the same cycle -> no overflow
    do_start(8'h08);
    chk("t4b_ovf_clr", trace_overflow, 0);
    for (int i = 0; i < 16; i++) wr(8'(i), 3'(i), 16'h0200 + 16'(i));
    trace_ready = 1'b1;
    wr(8'd16, 3'd0, 16'h0210);
    trace_ready = 1'b0;
    chk("t4b_ovf", trace_overflow, 0);
    hold_wait("t4b_done", 8'h40);
    for (int i = 1; i < 17; i++) pop_chk("t4b_trace", {8'(i), 3'(i), 16'h0200 + 16'(i)});
    chk("t4b_empty", trace_valid, 0);

    // 5: toggling PC never halts -> timeout at 64 RUN cycles
    do_start(8'h08);
    begin
      int n = 0;
      while (!done && n < 300) begin
        pc_in = 8'(n & 1);
        tick();
        n++;
      end
    end
    chk("t5_done", done, 1);
    chk("t5_to", timeout, 1);
    chk("t5_cyc", cycle_count, 64);
    chk("t5_pass", pass, 0);

    // 6: reset mid-run drops expectations; empty check passes
    do_start(8'h30);
    wr(8'h31, 3'd2, 16'h1234);
    reset_n = 1'b0;
    #3;
    chk("t6_rst_done", done, 0);
    chk("t6_rst_cyc", cycle_count, 0);
    reset_n = 1'b1;
    tick();
    do_start(8'h30);
    hold_wait("t6_done", 8'h30);
    chk("t6_pass", pass, 1);
    chk("t6_mask", fail_mask, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
